sign_extender: RTL and testbench



---
 rtl/mips_pkg.sv | 21 ++
 rtl/sign_extend_comb.sv | 42 ++++
 rtl/sign_extender.sv | 49 ++++
 tb/tb_sign_extender.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// +----------------------------------------------------------------------+
// | mips_pkg : shared MIPS datapath types and widths                     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package mips_pkg;

    localparam int IMM_W  = 16;
    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        EXT_SIGN   = 2'd0,
        EXT_ZERO   = 2'd1,
        EXT_LUI    = 2'd2,
        EXT_BRANCH = 2'd3
    } ext_mode_t;

endpackage

`default_nettype wire

// File: rtl/sign_extend_comb.sv
// +----------------------------------------------------------------------+
// | sign_extend_comb : zero-latency immediate extender (in, mode -> out) |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module sign_extend_comb
    import mips_pkg::*;
#(
    parameter int IN_W  = IMM_W,
    parameter int OUT_W = WORD_W
) (
    input  logic [IN_W-1:0]  in,
    input  ext_mode_t        mode,
    output logic [OUT_W-1:0] result
);

    generate
        if (OUT_W <= IN_W) begin : g_width_check
            $error("sign_extend_comb: OUT_W must exceed IN_W");
        end
    endgenerate

    logic [OUT_W-1:0] w_sext;

    assign w_sext = {{(OUT_W-IN_W){in[IN_W-1]}}, in};

    always_comb begin
        result = w_sext;
        unique case (mode)
            EXT_SIGN:   result = w_sext;
            EXT_ZERO:   result = {{(OUT_W-IN_W){1'b0}}, in};
            EXT_LUI:    result = {in, {(OUT_W-IN_W){1'b0}}};
            // Word-offset to byte-offset; bits pushed past the MSB are dropped.
            EXT_BRANCH: result = {w_sext[OUT_W-3:0], 2'b00};
            default:    result = w_sext;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/sign_extender.sv
// +----------------------------------------------------------------------+
// | sign_extender : registered immediate extender with valid flag        |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module sign_extender
    import mips_pkg::*;
#(
    parameter int               IN_W      = IMM_W,
    parameter int               OUT_W     = WORD_W,
    parameter logic [OUT_W-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [1:0]       mode,
    input  logic [IN_W-1:0]  in,
    output logic [OUT_W-1:0] out,
    output logic             out_valid
);

    logic [OUT_W-1:0] w_result;

    sign_extend_comb #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W)
    ) u_comb (
        .in     (in),
        .mode   (ext_mode_t'(mode)),
        .result (w_result)
    );

    // out keeps its last value on idle cycles; only the flag drops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out       <= RESET_VAL;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                out <= w_result;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_sign_extender.sv
// +----------------------------------------------------------------------+
// | tb_sign_extender : directed and random checks for sign_extender      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_sign_extender;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [1:0]  mode;
    logic [15:0] in;
    logic [31:0] out;
    logic        out_valid;

    int n_checks;
    int n_fails;

    sign_extender #(
        .IN_W      (16),
        .OUT_W     (32),
        .RESET_VAL (32'h0000_0000)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .mode      (mode),
        .in        (in),
        .out       (out),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] ref_ext(input logic [1:0] m, input logic [15:0] x);
        logic signed [31:0] s;
        s = $signed(x);
        case (m)
            2'd0:    return s;
            2'd1:    return {16'h0000, x};
            2'd2:    return {16'h0000, x} << 16;
            default: return s * 4;
        endcase
    endfunction

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Drive at the falling edge, sample 1 time unit after the rising edge.
    task automatic step(input logic v, input logic [1:0] m, input logic [15:0] x);
        @(negedge clk);
        in_valid = v;
        mode     = m;
        in       = x;
        @(posedge clk);
        #1;
    endtask

    task automatic xfer(input string tag, input logic [1:0] m, input logic [15:0] x,
                        input logic [31:0] exp);
        step(1'b1, m, x);
        check32(tag, out, exp);
        check1({tag, "_vld"}, out_valid, 1'b1);
    endtask

    initial begin
        logic        v;
        logic [1:0]  m;
        logic [15:0] x;
        logic [31:0] exp_out;

        n_checks = 0;
        n_fails  = 0;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        mode     = 2'd0;
        in       = 16'h0000;

        #1;
        check32("reset_out", out, 32'h0000_0000);
        check1("reset_vld", out_valid, 1'b0);

        @(negedge clk);
        rst_n = 1'b1;

        // SIGN boundaries
        xfer("sign_7fff", 2'd0, 16'h7FFF, 32'h0000_7FFF);
        xfer("sign_8000", 2'd0, 16'h8000, 32'hFFFF_8000);
        xfer("sign_ffff", 2'd0, 16'hFFFF, 32'hFFFF_FFFF);

        // ZERO / LUI
        xfer("zero_8000", 2'd1, 16'h8000, 32'h0000_8000);
        xfer("zero_ffff", 2'd1, 16'hFFFF, 32'h0000_FFFF);
        xfer("lui_8000",  2'd2, 16'h8000, 32'h8000_0000);
        xfer("lui_1234",  2'd2, 16'h1234, 32'h1234_0000);

        // BRANCH
        xfer("br_ffff", 2'd3, 16'hFFFF, 32'hFFFF_FFFC);
        xfer("br_4000", 2'd3, 16'h4000, 32'h0001_0000);
        xfer("br_8000", 2'd3, 16'h8000, 32'hFFFE_0000);

        // Zero input in every mode
        xfer("zero_in_sign", 2'd0, 16'h0000, 32'h0000_0000);
        xfer("zero_in_zero", 2'd1, 16'h0000, 32'h0000_0000);
        xfer("zero_in_lui",  2'd2, 16'h0000, 32'h0000_0000);
        xfer("zero_in_br",   2'd3, 16'h0000, 32'h0000_0000);

        // Streaming in SIGN mode, then idle hold
        xfer("stream_0001", 2'd0, 16'h0001, 32'h0000_0001);
        xfer("stream_ffff", 2'd0, 16'hFFFF, 32'hFFFF_FFFF);
        xfer("stream_0000", 2'd0, 16'h0000, 32'h0000_0000);
        step(1'b0, 2'd1, 16'hABCD);
        check1("idle_vld", out_valid, 1'b0);
        check32("idle_hold", out, 32'h0000_0000);

        xfer("pre_rst", 2'd2, 16'hBEEF, 32'hBEEF_0000);

        // Mid-run async reset with an input in flight
        @(negedge clk);
        in_valid = 1'b1;
        mode     = 2'd0;
        in       = 16'h8000;
        #2;
        rst_n = 1'b0;
        #1;
        check32("async_rst_out", out, 32'h0000_0000);
        check1("async_rst_vld", out_valid, 1'b0);
        @(posedge clk);
        #1;
        check32("rst_hold_out", out, 32'h0000_0000);
        check1("rst_hold_vld", out_valid, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check32("post_rst_out", out, 32'hFFFF_8000);
        check1("post_rst_vld", out_valid, 1'b1);

        // Random against reference model
        exp_out = out;
        for (int i = 0; i < 1000; i++) begin
            v = 1'($urandom_range(0, 1));
            m = 2'($urandom_range(0, 3));
            x = 16'($urandom);
            step(v, m, x);
            if (v) exp_out = ref_ext(m, x);
            check1("rand_vld", out_valid, v);
            check32("rand_out", out, exp_out);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

`default_nettype wire
